// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit line encoder.
// A line value is {d_plus, d_minus}.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StEopSe0,
    StEopJ
  } tx_state_e;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam int unsigned STUFF_LIMIT_DEF  = 6;
  localparam int unsigned EOP_SE0_BITS_DEF = 2;

  // NRZI: a 0 toggles J<->K, a 1 holds the line.
  function automatic logic [1:0] nrzi_next(input logic [1:0] line, input logic tx_bit);
    if (tx_bit) begin
      return line;
    end
    return (line == LINE_J) ? LINE_K : LINE_J;
  endfunction

endpackage

// File: rtl/usb_stuff_counter.sv
// Counts consecutive transmitted 1s and flags when a stuffed 0 must be sent.
module usb_stuff_counter
  import usb_tx_pkg::*;
#(
  parameter int unsigned STUFF_LIMIT = STUFF_LIMIT_DEF
) (
  input  logic clk,
  input  logic n_rst,
  input  logic shift_enable,
  input  logic tx_bit,
  input  logic clear,
  output logic stuff_now
);

  localparam int unsigned CntW = $clog2(STUFF_LIMIT + 1);

  logic [CntW-1:0] ones_cnt_q, ones_cnt_d;

  always_comb begin
    ones_cnt_d = ones_cnt_q;
    if (shift_enable) begin
      if (clear || !tx_bit) begin
        ones_cnt_d = '0;
      end else begin
        ones_cnt_d = ones_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      ones_cnt_q <= '0;
    end else begin
      ones_cnt_q <= ones_cnt_d;
    end
  end

  assign stuff_now = (ones_cnt_q == CntW'(STUFF_LIMIT));

endmodule

// File: rtl/usb_encoder.sv
// USB transmit line encoder: bit stuffing, NRZI encoding and EOP generation,
// advanced one bit time per shift_enable strobe.
module usb_encoder
  import usb_tx_pkg::*;
#(
  parameter int unsigned STUFF_LIMIT  = STUFF_LIMIT_DEF,
  parameter int unsigned EOP_SE0_BITS = EOP_SE0_BITS_DEF
) (
  input  logic clk,
  input  logic n_rst,
  input  logic shift_enable,
  input  logic d_orig,
  input  logic bit_valid,
  input  logic send_eop,
  output logic bit_ack,
  output logic d_plus,
  output logic d_minus,
  output logic tx_busy,
  output logic eop_done,
  output logic tx_error
);

  localparam int unsigned EopW = $clog2(EOP_SE0_BITS + 1);

  tx_state_e       state_q, state_d;
  logic [1:0]      line_q, line_d;
  logic [EopW-1:0] eop_cnt_q, eop_cnt_d;
  logic            tx_busy_q, eop_done_q, eop_done_d, tx_error_q, tx_error_d;
  logic            cnt_bit, cnt_clear, stuff_now;

  usb_stuff_counter #(
    .STUFF_LIMIT(STUFF_LIMIT)
  ) u_stuff_counter (
    .clk         (clk),
    .n_rst       (n_rst),
    .shift_enable(shift_enable),
    .tx_bit      (cnt_bit),
    .clear       (cnt_clear),
    .stuff_now   (stuff_now)
  );

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    eop_cnt_d  = eop_cnt_q;
    eop_done_d = 1'b0;
    tx_error_d = 1'b0;
    bit_ack    = 1'b0;
    cnt_bit    = 1'b0;
    cnt_clear  = 1'b0;
    if (shift_enable) begin
      unique case (state_q)
        StIdle: begin
          cnt_clear = 1'b1;
          if (bit_valid) begin
            bit_ack   = 1'b1;
            cnt_clear = 1'b0;
            cnt_bit   = d_orig;
            line_d    = nrzi_next(line_q, d_orig);
            state_d   = StData;
          end
        end
        StData: begin
          if (stuff_now) begin
            // Stuffed 0 outranks everything; upstream keeps d_orig for next time.
            cnt_bit = 1'b0;
            line_d  = nrzi_next(line_q, 1'b0);
          end else if (bit_valid) begin
            bit_ack = 1'b1;
            cnt_bit = d_orig;
            line_d  = nrzi_next(line_q, d_orig);
          end else begin
            // Normal or abort EOP; an abort additionally flags underflow.
            cnt_clear  = 1'b1;
            line_d     = LINE_SE0;
            eop_cnt_d  = EopW'(1);
            tx_error_d = !send_eop;
            state_d    = StEopSe0;
          end
        end
        StEopSe0: begin
          cnt_clear = 1'b1;
          if (eop_cnt_q < EopW'(EOP_SE0_BITS)) begin
            eop_cnt_d = eop_cnt_q + 1'b1;
          end else begin
            line_d  = LINE_J;
            state_d = StEopJ;
          end
        end
        StEopJ: begin
          cnt_clear  = 1'b1;
          line_d     = LINE_J;
          eop_cnt_d  = '0;
          eop_done_d = 1'b1;
          state_d    = StIdle;
        end
        default: begin
          cnt_clear = 1'b1;
          line_d    = LINE_J;
          eop_cnt_d = '0;
          state_d   = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= StIdle;
      line_q     <= LINE_J;
      eop_cnt_q  <= '0;
      tx_busy_q  <= 1'b0;
      eop_done_q <= 1'b0;
      tx_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      eop_cnt_q  <= eop_cnt_d;
      tx_busy_q  <= (state_d != StIdle);
      eop_done_q <= eop_done_d;
      tx_error_q <= tx_error_d;
    end
  end

  assign d_plus   = line_q[1];
  assign d_minus  = line_q[0];
  assign tx_busy  = tx_busy_q;
  assign eop_done = eop_done_q;
  assign tx_error = tx_error_q;

endmodule

// File: tb/tb_usb_encoder.sv
// Directed self-checking bench for usb_encoder with hand-computed line sequences.
module tb_usb_encoder;

  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  logic clk = 1'b0;
  logic n_rst, shift_enable, d_orig, bit_valid, send_eop;
  logic bit_ack, d_plus, d_minus, tx_busy, eop_done, tx_error;
  logic ack;
  int   checks = 0;
  int   errors = 0;
  int   ack_cnt;

  always #5 clk = ~clk;

  usb_encoder dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .shift_enable(shift_enable),
    .d_orig      (d_orig),
    .bit_valid   (bit_valid),
    .send_eop    (send_eop),
    .bit_ack     (bit_ack),
    .d_plus      (d_plus),
    .d_minus     (d_minus),
    .tx_busy     (tx_busy),
    .eop_done    (eop_done),
    .tx_error    (tx_error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One bit time: strobe with the given inputs, capture bit_ack before the edge.
  task automatic strobe(input logic v, input logic d, input logic eop, output logic a);
    @(negedge clk);
    bit_valid    = v;
    d_orig       = d;
    send_eop     = eop;
    shift_enable = 1'b1;
    #1 a = bit_ack;
    @(posedge clk);
    #1 shift_enable = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst        = 1'b0;
    shift_enable = 1'b0;
    bit_valid    = 1'b0;
    send_eop     = 1'b0;
    d_orig       = 1'b0;
    @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  task automatic chk_line(input string tag, input logic [1:0] exp);
    chk(tag, {30'd0, d_plus, d_minus}, {30'd0, exp});
  endtask

  initial begin
    logic [1:0] exp_line;
    n_rst = 1'b0; shift_enable = 1'b0; bit_valid = 1'b0; send_eop = 1'b0; d_orig = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_line("rst_line", J);
    chk("rst_busy", tx_busy, 0);
    chk("rst_eop_done", eop_done, 0);
    chk("rst_tx_error", tx_error, 0);
    chk("rst_bit_ack", bit_ack, 0);
    n_rst = 1'b1;

    // send_eop alone in IDLE does nothing
    strobe(1'b0, 1'b0, 1'b1, ack);
    chk("idle_eop_ign_busy", tx_busy, 0);
    chk_line("idle_eop_ign_line", J);
    chk("idle_eop_ign_ack", ack, 0);

    // 1: eight 0s toggle the line every bit
    ack_cnt = 0;
    exp_line = J;
    for (int i = 0; i < 8; i++) begin
      strobe(1'b1, 1'b0, 1'b0, ack);
      ack_cnt += int'(ack);
      exp_line = (exp_line == J) ? K : J;
      chk_line($sformatf("t1_line%0d", i), exp_line);
      chk("t1_busy", tx_busy, 1);
    end
    chk("t1_acks", ack_cnt, 8);

    // 6: no strobes for 20 cycles mid-packet -> nothing moves
    @(negedge clk);
    bit_valid = 1'b1; d_orig = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t6_ack", bit_ack, 0);
      chk_line("t6_line", J);
      chk("t6_busy", tx_busy, 1);
    end

    // 2: seven 1s from a fresh packet -> stuffed K after six
    do_reset();
    ack_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      strobe(1'b1, 1'b1, 1'b0, ack);
      ack_cnt += int'(ack);
      chk_line($sformatf("t2_hold%0d", i), J);
    end
    strobe(1'b1, 1'b1, 1'b0, ack);
    chk("t2_stuff_ack", ack, 0);
    chk_line("t2_stuff_line", K);
    strobe(1'b1, 1'b1, 1'b0, ack);
    ack_cnt += int'(ack);
    chk_line("t2_held_one", K);
    chk("t2_acks", ack_cnt, 7);

    // bit_valid beats send_eop
    strobe(1'b1, 1'b0, 1'b1, ack);
    chk("both_ack", ack, 1);
    chk_line("both_line", J);

    // 3: six 1s, then request EOP -> stuff first, then SE0 SE0 J
    do_reset();
    for (int i = 0; i < 6; i++) strobe(1'b1, 1'b1, 1'b0, ack);
    strobe(1'b0, 1'b0, 1'b1, ack);
    chk("t3_stuff_ack", ack, 0);
    chk_line("t3_stuff", K);
    strobe(1'b0, 1'b0, 1'b1, ack);
    chk_line("t3_se0a", SE0);
    chk("t3_no_err", tx_error, 0);
    strobe(1'b0, 1'b0, 1'b1, ack);
    chk_line("t3_se0b", SE0);
    chk("t3_eop_ack", ack, 0);
    strobe(1'b0, 1'b0, 1'b1, ack);
    chk_line("t3_j", J);
    chk("t3_j_busy", tx_busy, 1);
    chk("t3_j_done", eop_done, 0);
    strobe(1'b1, 1'b0, 1'b0, ack);
    chk("t3_ej_ack", ack, 0);
    chk("t3_done", eop_done, 1);
    chk("t3_busy", tx_busy, 0);
    chk_line("t3_idle_line", J);
    @(posedge clk); #1;
    chk("t3_done_pulse", eop_done, 0);
    strobe(1'b0, 1'b0, 1'b0, ack);
    chk_line("t3_after", J);
    chk("t3_after_busy", tx_busy, 0);

    // 4: underflow mid-packet -> abort EOP with tx_error
    do_reset();
    strobe(1'b1, 1'b0, 1'b0, ack);
    chk_line("t4_k", K);
    strobe(1'b0, 1'b0, 1'b0, ack);
    chk_line("t4_se0a", SE0);
    chk("t4_err", tx_error, 1);
    @(posedge clk); #1;
    chk("t4_err_pulse", tx_error, 0);
    strobe(1'b0, 1'b0, 1'b0, ack);
    chk_line("t4_se0b", SE0);
    strobe(1'b0, 1'b0, 1'b0, ack);
    chk_line("t4_j", J);
    strobe(1'b0, 1'b0, 1'b0, ack);
    chk("t4_done", eop_done, 1);
    chk("t4_err_once", tx_error, 0);

    // 5: reset during EOP_SE0
    do_reset();
    strobe(1'b1, 1'b0, 1'b0, ack);
    strobe(1'b0, 1'b0, 1'b1, ack);
    chk_line("t5_se0", SE0);
    do_reset();
    chk_line("t5_line", J);
    chk("t5_busy", tx_busy, 0);
    chk("t5_done", eop_done, 0);

    // reset mid-run of 1s must clear the ones count
    for (int i = 0; i < 5; i++) strobe(1'b1, 1'b1, 1'b0, ack);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      strobe(1'b1, 1'b1, 1'b0, ack);
      chk($sformatf("t5_fresh_ack%0d", i), ack, 1);
    end
    chk_line("t5_fresh_line", J);
    strobe(1'b1, 1'b1, 1'b0, ack);
    chk("t5_stuff_ack", ack, 0);
    chk_line("t5_stuff_line", K);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/usb_encoder.md
Name: usb_encoder

Overview:
- Transmit-side USB line encoder. Accepts one original data bit per bit time from an upstream serializer, bit-stuffs it, NRZI-encodes it, and drives the differential pair d_plus/d_minus.
- On request, terminates the packet with an EOP sequence: SE0 for EOP_SE0_BITS bit times, then one J bit.
- Bit timing comes from an external shift_enable strobe (one clk-cycle pulse per bit time). The block sits between the transmit shift register and the pad drivers.

Parameters:
- STUFF_LIMIT, 6, number of consecutive transmitted 1s after which a stuffed 0 is forced.
- EOP_SE0_BITS, 2, number of bit times SE0 is driven during EOP.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- n_rst  input  1  synchronous active-low reset.
- shift_enable  input  1  bit-time strobe; high for exactly one clk cycle per bit.
- d_orig  input  1  original (unencoded) data bit offered by upstream.
- bit_valid  input  1  d_orig holds a bit to send.
- send_eop  input  1  upstream has no more bits; end the packet.
- bit_ack  output  1  combinational; high in the shift_enable cycle in which d_orig is consumed.
- d_plus  output  1  registered line D+.
- d_minus  output  1  registered line D-.
- tx_busy  output  1  registered; high in every state except IDLE.
- eop_done  output  1  registered one-cycle pulse when the trailing J bit completes.
- tx_error  output  1  registered one-cycle pulse on underflow (see below).

Behaviour:
- Reset: sampled on a clk edge with n_rst=0.
  - Outputs: d_plus=1, d_minus=0 (J), tx_busy=0, eop_done=0, tx_error=0, bit_ack=0.
  - Internal: state=IDLE, ones_cnt=0, eop_cnt=0.
  - Applies from any state, including mid-packet and mid-EOP. No EOP is emitted on reset.
- Line encodings: J = (1,0), K = (0,1), SE0 = (0,0).
- NRZI: a transmitted 0 toggles the line (J<->K); a transmitted 1 holds it.
- Advance rule: all state, counter and line updates happen only on edges where shift_enable=1. Otherwise everything holds.
- Latency: line outputs change on the clk edge that ends the shift_enable cycle.
- ones_cnt:
  - Increments on each transmitted 1.
  - Clears on each transmitted 0, including stuffed 0s.
  - Clears on entry to EOP.
  - Width is clog2(STUFF_LIMIT+1).
- IDLE (line J):
  - shift_enable & bit_valid: encode d_orig, bit_ack=1, go to DATA.
  - send_eop is ignored in IDLE.
- DATA: on shift_enable, the first matching rule applies:
  1. ones_cnt==STUFF_LIMIT: emit a stuffed 0 (toggle). bit_ack=0, so upstream holds d_orig. Stuffing takes priority over both bit_valid and send_eop.
  2. bit_valid: encode d_orig, bit_ack=1.
  3. send_eop: drive SE0, eop_cnt=1, go to EOP_SE0.
  4. Neither (underflow): drive SE0, pulse tx_error, eop_cnt=1, go to EOP_SE0. This is an abort EOP.
- EOP_SE0:
  - On shift_enable with eop_cnt<EOP_SE0_BITS: hold SE0, increment eop_cnt.
  - On shift_enable with eop_cnt==EOP_SE0_BITS: drive J, go to EOP_J.
- EOP_J: on shift_enable, hold J, pulse eop_done, clear counters, go to IDLE.
- bit_valid and send_eop both high: bit_valid wins. EOP begins only once bit_valid drops.
- bit_ack is never asserted outside a shift_enable cycle, and never while in EOP_SE0 or EOP_J.

Decomposition:
- Shared package usb_tx_pkg holds:
  - state enum: IDLE, DATA, EOP_SE0, EOP_J;
  - line constants LINE_J, LINE_K, LINE_SE0 as 2-bit {d_plus, d_minus};
  - default STUFF_LIMIT and EOP_SE0_BITS.
- One natural sub-module: usb_stuff_counter.
  - Inputs: clk, n_rst, shift_enable, tx_bit, clear.
  - Output: stuff_now.
  - Owns ones_cnt and its synchronous reset.

Test Plan:
1. Reset, then send 0x00 LSB-first (eight 0s, one shift_enable each) -> d_plus sequence 0,1,0,1,0,1,0,1; d_minus always its complement; 8 bit_ack pulses; tx_busy=1 after the first edge.
2. Seven consecutive 1s -> line held J for six bit times; the seventh shift_enable produces a K with bit_ack=0; the eighth sends the held 1 (stays K); exactly 7 bit_acks in 8 strobes.
3. After six 1s, drop bit_valid and raise send_eop -> stuffed K first, then SE0 for 2 strobes, then J, one eop_done pulse, tx_busy=0, next strobe leaves the line at J.
4. Mid-packet, with bit_valid=0 and send_eop=0 at a strobe -> tx_error pulses once; SE0,SE0,J sequence follows; eop_done pulses.
5. Assert n_rst=0 for one edge during EOP_SE0 -> the next cycle shows d_plus=1, d_minus=0, tx_busy=0, no eop_done; a new packet then starts cleanly with ones_cnt=0.
6. shift_enable held low for 20 cycles with bit_valid=1 -> no output change and bit_ack=0 throughout.
